mdu_sequencer: RTL and testbench
================================

// Module: mdu_sequencer
// PURPOSE
//  Iterative multiply/divide sequencer: RV32M ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU)
//  executed with one 33-bit add/sub per cycle.
//  Sits beside the single-cycle ALU in EX. Core stalls on o_ready/o_valid handshakes.
// PARAMETERS
//  XLEN   32   operand/result width; iteration count = XLEN
// PORTS
//  i_clk     in   1     clock; all state updates on rising edge
//  i_rst     in   1     reset, asynchronous, active-high
//  i_valid   in   1     request valid; accepted when i_valid && o_ready
//  o_ready   out  1     sequencer idle, can accept
//  i_op      in   3     funct3: 000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  i_1,i_2   in   XLEN  rs1, rs2 (sampled only at accept)
//  o_valid   out  1     result valid; held until i_ready
//  i_ready   in   1     consumer takes result when o_valid && i_ready
//  o_1       out  XLEN  result; stable while o_valid
//  o_busy    out  1     high in CALC/FIX/DONE
// BEHAVIOUR
//  Reset: state IDLE; o_ready=1, o_valid=0, o_busy=0, o_1=0, counter=0, operand regs=0.
//  FSM: IDLE -(i_valid)-> CALC -(cnt==XLEN-1)-> FIX -> DONE -(i_ready)-> IDLE.
//  Latency: accept at edge of cycle N; CALC cycles N+1..N+XLEN; FIX at N+XLEN+1.
//   o_valid rises in cycle N+XLEN+2 (34 for XLEN=32).
//  o_ready=1 only in IDLE: no back-to-back accept. DONE&&i_ready -> IDLE next cycle.
//  Inputs are ignored outside IDLE. i_valid in DONE is not accepted.
//  Signedness at accept: rs1 signed for MUL*/DIV/REM except MULHU/DIVU/REMU.
//   rs2 signed for MULH/DIV/REM only. Registers |operand| as unsigned XLEN bits.
//   |-2^31| = 0x8000_0000 fits unsigned. Records neg_res and neg_rem.
//  MUL*: shift-add, 2*XLEN product register, 1 multiplier bit per CALC cycle.
//   FIX negates the product if neg_res.
//   MUL returns low half; MULH/MULHSU/MULHU return high half.
//  DIV*/REM*: restoring division, 1 quotient bit per cycle. Uses 33-bit trial subtract.
//   FIX: quotient negated if neg_res (sign(rs1) xor sign(rs2)).
//   FIX: remainder negated if neg_rem (rs1 negative).
//  Divide by zero (rs2==0): quotient=all ones, remainder=rs1. Forced in FIX regardless of signs.
//  Overflow DIV -2^31/-1: quotient=0x8000_0000, REM=0. Falls out of magnitude path; no special case.
//  Counter wraps 0..XLEN-1 only; never counts outside CALC.
//  Async reset mid-operation: immediate IDLE, result discarded, o_valid drops same cycle.
// CONFIGURATION
//  MDU_EARLY_DONE_EN defined: at accept, rs2==0 (DIV*/REM*) or either operand==0 (MUL*)
//   goes IDLE->FIX directly; result produced in FIX. o_valid in cycle N+2.
//  Undefined: every op runs full XLEN CALC cycles; fixed latency N+XLEN+2. Results identical.
// STRUCTURE
//  mdu_pkg: XLEN default, funct3 localparams (OP_MUL..OP_REMU), state enum (IDLE,CALC,FIX,DONE).
//   Helper function is_signed_rs1/rs2(op).
//  Sub-module mdu_step: combinational one-iteration datapath.
//   Inputs: acc, operand, mode. Output: next acc plus bit (add-shift for mul, trial-sub-shift for div).
//   Instantiated once. FSM, counter, sign and result regs stay in mdu_sequencer.
// TESTING
//  MULHU 0xFFFF_FFFF*0xFFFF_FFFF -> o_1=0xFFFF_FFFE. o_valid exactly 34 cycles after accept.
//  MULH 0x8000_0000*0x8000_0000 -> 0x4000_0000. MUL -3*7 -> 0xFFFF_FFEB.
//   MULHSU -1*0xFFFF_FFFF -> 0xFFFF_FFFF.
//  DIV -7/2 -> 0xFFFF_FFFD. REM -7/2 -> 0xFFFF_FFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
//  DIV 0x8000_0000/-1 -> 0x8000_0000, REM -> 0.
//   DIV 5/0 -> 0xFFFF_FFFF, REM 5/0 -> 5.
//   With MDU_EARLY_DONE_EN, the /0 cases give o_valid at cycle N+2.
//  Hold i_ready=0 for 10 cycles in DONE -> o_valid/o_1 stable, o_ready=0.
//   New i_valid is ignored. Accept resumes 1 cycle after i_ready.
//  Assert i_rst at CALC cycle 15 -> o_valid=0, o_ready=1 immediately.
//   Next request completes correctly with full latency.

Source files
------------

// File: rtl/mdu_pkg.sv
// ============================================================================
// Module   : mdu_pkg
// Purpose  : Shared definitions for the iterative multiply/divide sequencer.
//            Holds the default width, the funct3 opcode encodings, the FSM
//            state type and the operand-signedness helpers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

  localparam int XLEN_DEFAULT = 32;

  // funct3 encodings of the RV32M group
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // rs1 is treated as signed by every op except the fully unsigned ones
  function automatic logic is_signed_rs1(input logic [2:0] op);
    return (op != OP_MULHU) && (op != OP_DIVU) && (op != OP_REMU);
  endfunction

  // rs2 is signed only for the fully signed high multiply and signed divide
  function automatic logic is_signed_rs2(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // funct3[2] separates the divide/remainder group from the multiplies
  function automatic logic is_div_op(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_if.sv
// ============================================================================
// Module   : mdu_if
// Purpose  : Request/response handshake bundle between the core EX stage
//            (master) and the multiply/divide sequencer (slave). Signal
//            names are written from the sequencer's point of view.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mdu_if #(
  parameter int XLEN = mdu_pkg::XLEN_DEFAULT
);

  logic            i_valid;
  logic            o_ready;
  logic [2:0]      i_op;
  logic [XLEN-1:0] i_1;
  logic [XLEN-1:0] i_2;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_1;
  logic            o_busy;

  modport master (
    output i_valid, i_op, i_1, i_2, i_ready,
    input  o_ready, o_valid, o_1, o_busy
  );

  modport slave (
    input  i_valid, i_op, i_1, i_2, i_ready,
    output o_ready, o_valid, o_1, o_busy
  );

endinterface

`default_nettype wire

// File: rtl/mdu_step.sv
// ============================================================================
// Module   : mdu_step
// Purpose  : One iteration of the shared multiply/divide datapath, built
//            around a single (XLEN+1)-bit adder/subtractor.
//            Multiply : shift-add; the low half of the accumulator holds the
//                       remaining multiplier bits, the high half the partial
//                       product. o_bit is the multiplier bit consumed.
//            Divide   : restoring division; high half is the partial
//                       remainder, low half shifts dividend bits out and
//                       quotient bits in. o_bit is the new quotient bit and
//                       is left for the caller to place in o_acc[0].
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_step
  import mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  wire logic [2*XLEN-1:0] i_acc,
  input  wire logic [XLEN-1:0]   i_operand,
  input  wire logic              i_div,
  output logic      [2*XLEN-1:0] o_acc,
  output logic                   o_bit
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_top;
  logic [XLEN:0] w_trial;

  // Single iteration: add-and-shift-right for multiply, shift-left-and-trial-subtract for divide
  always_comb begin
    w_sum   = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_operand} : '0);
    // partial remainder shifted left with the next dividend bit appended;
    // it is always below 2*divisor, so the 33-bit difference cannot wrap
    w_top   = {i_acc[2*XLEN-1:XLEN], i_acc[XLEN-1]};
    w_trial = w_top - {1'b0, i_operand};
    o_acc   = '0;
    o_bit   = 1'b0;
    if (i_div) begin
      o_bit = ~w_trial[XLEN];
      o_acc = {(o_bit ? w_trial[XLEN-1:0] : w_top[XLEN-1:0]),
               i_acc[XLEN-2:0], 1'b0};
    end else begin
      o_bit = i_acc[0];
      o_acc = {w_sum, i_acc[XLEN-1:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/mdu_sequencer.sv
// ============================================================================
// Module   : mdu_sequencer
// Purpose  : Iterative RV32M multiply/divide unit. Operands are converted to
//            unsigned magnitudes at accept, XLEN iterations of mdu_step run
//            in CALC, signs and divide-by-zero are applied in FIX, and the
//            result is held in DONE until the consumer takes it.
// Options  : MDU_EARLY_DONE_EN - when defined, a zero divisor (DIV*/REM*) or
//            a zero operand (MUL*) skips CALC and goes straight to FIX.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input wire logic i_clk,
  input wire logic i_rst,
  mdu_if.slave     bus
);

  localparam int                  c_CNT_W    = $clog2(XLEN);
  localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(XLEN - 1);

`ifdef MDU_EARLY_DONE_EN
  localparam logic c_EARLY = 1'b1;
`else
  localparam logic c_EARLY = 1'b0;
`endif

  state_t              r_state;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_operand;
  logic [XLEN-1:0]     r_rs1;
  logic [2:0]          r_op;
  logic                r_neg_res;
  logic                r_neg_rem;
  logic                r_div0;
  logic                r_ready;
  logic                r_valid;
  logic                r_busy;
  logic [XLEN-1:0]     r_result;

  logic                w_is_div;
  logic                w_a_neg;
  logic                w_b_neg;
  logic [XLEN-1:0]     w_a_mag;
  logic [XLEN-1:0]     w_b_mag;
  logic                w_zero_case;
  logic                w_early;
  logic [2*XLEN-1:0]   w_step_acc;
  logic                w_step_bit;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_quo;
  logic [XLEN-1:0]     w_rem;
  logic [XLEN-1:0]     w_result;

  assign bus.o_ready = r_ready;
  assign bus.o_valid = r_valid;
  assign bus.o_busy  = r_busy;
  assign bus.o_1     = r_result;

  // Operand conditioning at accept: signs and unsigned magnitudes
  assign w_is_div    = is_div_op(bus.i_op);
  assign w_a_neg     = is_signed_rs1(bus.i_op) & bus.i_1[XLEN-1];
  assign w_b_neg     = is_signed_rs2(bus.i_op) & bus.i_2[XLEN-1];
  assign w_a_mag     = w_a_neg ? -bus.i_1 : bus.i_1;
  assign w_b_mag     = w_b_neg ? -bus.i_2 : bus.i_2;
  assign w_zero_case = w_is_div ? (bus.i_2 == '0)
                                : ((bus.i_1 == '0) || (bus.i_2 == '0));
  assign w_early     = c_EARLY & w_zero_case;

  mdu_step #(
    .XLEN (XLEN)
  ) u_step (
    .i_acc     (r_acc),
    .i_operand (r_operand),
    .i_div     (r_op[2]),
    .o_acc     (w_step_acc),
    .o_bit     (w_step_bit)
  );

  // Sign fix-up and result selection evaluated while in FIX
  always_comb begin
    w_prod   = r_neg_res ? -r_acc : r_acc;
    w_quo    = r_neg_res ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    w_rem    = r_neg_rem ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    // a zero divisor overrides whatever the magnitude path produced
    if (r_div0) begin
      w_quo = '1;
      w_rem = r_rs1;
    end
    w_result = '0;
    case (r_op)
      OP_MUL:                       w_result = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_result = w_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              w_result = w_quo;
      default:                      w_result = w_rem;
    endcase
  end

  // Control FSM with iteration counter, operand registers and registered handshake outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_operand <= '0;
      r_rs1     <= '0;
      r_op      <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
      r_ready   <= 1'b1;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_result  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.i_valid) begin
            r_op      <= bus.i_op;
            r_rs1     <= bus.i_1;
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_div0    <= (bus.i_2 == '0);
            r_cnt     <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
            if (w_is_div) begin
              r_acc     <= {{XLEN{1'b0}}, w_a_mag};
              r_operand <= w_b_mag;
            end else begin
              r_acc     <= {{XLEN{1'b0}}, w_b_mag};
              r_operand <= w_a_mag;
            end
            if (w_early) begin
              // product of a zero operand is zero; divide-by-zero is forced in FIX
              r_acc   <= '0;
              r_state <= FIX;
            end else begin
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_acc <= r_op[2] ? {w_step_acc[2*XLEN-1:1], w_step_bit} : w_step_acc;
          if (r_cnt == c_CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= FIX;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        FIX: begin
          r_result <= w_result;
          r_valid  <= 1'b1;
          r_state  <= DONE;
        end
        DONE: begin
          if (bus.i_ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mdu_sequencer.sv
// ============================================================================
// Module   : tb_mdu_sequencer
// Purpose  : Self-checking bench for mdu_sequencer. A behavioural model
//            (RV32M arithmetic plus request/latency/handshake tracking) is
//            compared against the DUT outputs every cycle; directed vectors
//            with literal results pin the model, followed by random traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_sequencer;
  import mdu_pkg::*;

  localparam int W = 32;

`ifdef MDU_EARLY_DONE_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mdu_if #(.XLEN(W)) bus();

  mdu_sequencer #(.XLEN(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // ---------------------------------------------------------------- reference
  function automatic logic [31:0] ref_mdu(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    p  = '0;
    case (op)
      OP_MUL:    begin p = sa * sb; return p[31:0]; end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      OP_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb;
        return p[31:0];
      end
      OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb;
        return p[31:0];
      end
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  // cycles from the accept edge to the first cycle with o_valid high
  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic zero;
    zero = op[2] ? (b == 0) : (a == 0 || b == 0);
    return (EARLY && zero) ? 2 : W + 2;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  logic        m_pend = 1'b0;
  int          m_age  = 0;
  int          m_lat  = W + 2;
  logic [31:0] m_res  = '0;
  logic [31:0] m_last = '0;

  // Transaction-level view: one request outstanding, result after its latency
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend <= 1'b0;
      m_age  <= 0;
      m_last <= '0;
    end else if (m_pend) begin
      if (m_age >= m_lat && bus.i_ready) begin
        m_pend <= 1'b0;
        m_last <= m_res;
      end else begin
        m_age <= m_age + 1;
      end
    end else if (bus.i_valid) begin
      m_pend <= 1'b1;
      m_age  <= 1;
      m_res  <= ref_mdu(bus.i_op, bus.i_1, bus.i_2);
      m_lat  <= ref_lat(bus.i_op, bus.i_1, bus.i_2);
    end
  end

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    if (rst || $time > 2) begin
      chk("o_ready", 32'(bus.o_ready), 32'(!m_pend));
      chk("o_busy",  32'(bus.o_busy),  32'(m_pend));
      chk("o_valid", 32'(bus.o_valid), 32'(m_pend && m_age >= m_lat));
      chk("o_1",     bus.o_1, (m_pend && m_age >= m_lat) ? m_res : m_last);
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int hold, input string name);
    int n;
    int lat;
    @(posedge clk); #2;
    bus.i_valid = 1'b1;
    bus.i_op    = op;
    bus.i_1     = a;
    bus.i_2     = b;
    n = 0;
    while (!bus.o_ready && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 200) begin
      chk({name, "_accept_timeout"}, 32'(n), 32'd0);
      bus.i_valid = 1'b0;
      return;
    end
    @(posedge clk); #2;
    // post-accept noise on the request side must be ignored
    bus.i_valid = 1'($urandom_range(0, 1));
    bus.i_op    = 3'($urandom);
    bus.i_1     = $urandom;
    bus.i_2     = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.o_valid && lat < 100);
    chk(name, bus.o_1, exp);
    chk({name, "_latency"}, 32'(lat), 32'(ref_lat(op, a, b)));
    if (hold > 0) begin
      @(posedge clk); #2;
      bus.i_valid = 1'b1;
      bus.i_op    = OP_MUL;
      repeat (hold) @(posedge clk);
      #2;
      chk({name, "_hold_ready"}, 32'(bus.o_ready), 32'd0);
      chk({name, "_hold_valid"}, 32'(bus.o_valid), 32'd1);
      chk({name, "_hold_o1"}, bus.o_1, exp);
    end
    @(posedge clk); #2;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    @(posedge clk); #2;
    bus.i_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    bus.i_valid = 1'b0;
    bus.i_op    = '0;
    bus.i_1     = '0;
    bus.i_2     = '0;
    bus.i_ready = 1'b0;
    #1 rst = 1'b1;

    // pin the reference model with hand-computed results
    chk("ref_mulhu", ref_mdu(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
    chk("ref_mulh",  ref_mdu(OP_MULH,   32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
    chk("ref_mul",   ref_mdu(OP_MUL,    32'hFFFF_FFFD, 32'd7),         32'hFFFF_FFEB);
    chk("ref_mulhsu",ref_mdu(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
    chk("ref_div",   ref_mdu(OP_DIV,    32'hFFFF_FFF9, 32'd2),         32'hFFFF_FFFD);
    chk("ref_rem",   ref_mdu(OP_REM,    32'hFFFF_FFF9, 32'd2),         32'hFFFF_FFFF);
    chk("ref_divu",  ref_mdu(OP_DIVU,   32'd100,       32'd7),         32'd14);
    chk("ref_remu",  ref_mdu(OP_REMU,   32'd100,       32'd7),         32'd2);
    chk("ref_divov", ref_mdu(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    chk("ref_remov", ref_mdu(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF), 32'h0);
    chk("ref_div0",  ref_mdu(OP_DIV,    32'd5,         32'd0),         32'hFFFF_FFFF);
    chk("ref_rem0",  ref_mdu(OP_REM,    32'd5,         32'd0),         32'd5);

    repeat (3) @(posedge clk);
    #2;
    chk("rst_ready", 32'(bus.o_ready), 32'd1);
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_busy",  32'(bus.o_busy),  32'd0);
    chk("rst_o1",    bus.o_1,          32'd0);
    rst = 1'b0;

    // directed vectors with literal results
    run(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "mulhu");
    run(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, "mulh");
    run(OP_MUL,    32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 0, "mul");
    run(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu");
    run(OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0, "div");
    run(OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0, "rem");
    run(OP_DIVU,   32'd100,       32'd7,         32'd14,        0, "divu");
    run(OP_REMU,   32'd100,       32'd7,         32'd2,        10, "remu_hold");
    run(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, "div_ovf");
    run(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         0, "rem_ovf");
    run(OP_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 0, "div_zero");
    run(OP_REM,    32'd5,         32'd0,         32'd5,         0, "rem_zero");
    run(OP_MUL,    32'd0,         32'h1234_5678, 32'd0,         0, "mul_zero");

    // asynchronous reset in the middle of CALC
    @(posedge clk); #2;
    bus.i_valid = 1'b1;
    bus.i_op    = OP_DIV;
    bus.i_1     = 32'd12345;
    bus.i_2     = 32'd17;
    @(posedge clk); #2;
    bus.i_valid = 1'b0;
    repeat (15) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(bus.o_valid), 32'd0);
    chk("midrst_ready", 32'(bus.o_ready), 32'd1);
    chk("midrst_busy",  32'(bus.o_busy),  32'd0);
    @(posedge clk); #3 rst = 1'b0;
    run(OP_DIVU, 32'd100, 32'd7, 32'd14, 0, "after_rst");

    // randomized traffic against the model
    for (int i = 0; i < 150; i++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      run(op, a, b, ref_mdu(op, a, b), $urandom_range(0, 3), "rand");
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
